// File: rtl/ar_rx_buf_if.sv
// Receiver-to-buffer word bus plus the show-ahead read port of the label-filtered RX buffer.
// The master drives the received words and pop requests; the slave returns the FIFO head.
interface ar_rx_buf_if;
  logic [7:0]  sr_adr;
  logic [22:0] sr_dat;
  logic        ce_wr;
  logic        rd;
  logic [7:0]  rd_adr;
  logic [22:0] rd_dat;
  logic        rd_vld;

  modport master (
    output sr_adr, sr_dat, ce_wr, rd,
    input  rd_adr, rd_dat, rd_vld
  );

  modport slave (
    input  sr_adr, sr_dat, ce_wr, rd,
    output rd_adr, rd_dat, rd_vld
  );
endinterface

// File: rtl/ar_rx_buf.sv
// Label-filtered show-ahead FIFO behind the ARINC receiver; a strobed word is visible one edge later.
// No backpressure to the receiver: words arriving while full are dropped, counted and flagged.
module ar_rx_buf #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  ar_rx_buf_if.slave    bus,
  input  logic          lbl_we,
  input  logic [7:0]    lbl_adr,
  input  logic          lbl_en,
  output logic [AW:0]   cnt,
  output logic          full,
  output logic          ovf,
  input  logic          ovf_clr,
  output logic [7:0]    drop_cnt
);

  localparam int          DEPTH   = 2**AW;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [7:0]  adr;
    logic [22:0] dat;
  } word_t;

  word_t          mem [DEPTH];
  logic [AW-1:0]  wp;
  logic [AW-1:0]  rp;
  logic [255:0]   lbl_tbl;
  logic           accept;
  logic           pop;
  logic           push;
  logic           drop;
  logic [AW:0]    cnt_nxt;
  word_t          head;

  // Table lookup uses the registered bit, so a same-edge table write filters with the old value.
  assign accept = bus.ce_wr & lbl_tbl[bus.sr_adr];
  assign pop    = bus.rd & bus.rd_vld;
  assign push   = accept & (~full | pop);
  assign drop   = accept & full & ~pop;

  always_comb begin
    cnt_nxt = cnt;
    case ({push, pop})
      2'b10:   cnt_nxt = cnt + 1'b1;
      2'b01:   cnt_nxt = cnt - 1'b1;
      default: cnt_nxt = cnt;
    endcase
  end

  assign head       = mem[rp];
  assign bus.rd_vld = (cnt != '0);
  assign bus.rd_adr = bus.rd_vld ? head.adr : '0;
  assign bus.rd_dat = bus.rd_vld ? head.dat : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= word_t'({bus.sr_adr, bus.sr_dat});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp   <= '0;
      rp   <= '0;
      cnt  <= '0;
      full <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      cnt  <= cnt_nxt;
      full <= (cnt_nxt == DEPTH_W);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lbl_tbl <= '1;
    end else if (lbl_we) begin
      lbl_tbl[lbl_adr] <= lbl_en;
    end
  end

  // A drop in the same cycle as a clear restarts the count at one rather than zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (ovf_clr)                drop_cnt <= 8'd1;
      else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
    end else if (ovf_clr) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: doc/ar_rx_buf.md
Name: ar_rx_buf

Overview:
- Receive-side word buffer sitting directly downstream of the ARINC-style serial receiver (AR_RXD).
- Consumes each decoded word (8-bit address/label + 23-bit data, strobed by ce_wr) and filters it against a programmable 256-entry label-accept table.
- Stores accepted words in a show-ahead FIFO for the host/consumer, with overflow flagging and a drop counter.

Parameters:
- AW, 4, FIFO address width; depth DEPTH = 2**AW words (default 16).

Ports:
- clk  in  1  system clock, same domain as receiver.
- rst_n  in  1  reset, asynchronous, active-low.
- sr_adr  in  8  received label (from receiver sr_adr).
- sr_dat  in  23  received data (from receiver sr_dat).
- ce_wr  in  1  one-cycle strobe: sr_adr/sr_dat valid (from receiver ce_wr).
- lbl_we  in  1  label-table write strobe.
- lbl_adr  in  8  label-table index.
- lbl_en  in  1  value written: 1 = accept label, 0 = reject.
- rd  in  1  pop request.
- rd_adr  out  8  head-of-FIFO label.
- rd_dat  out  23  head-of-FIFO data.
- rd_vld  out  1  FIFO not empty; rd_adr/rd_dat valid.
- cnt  out  AW+1  words stored, 0..DEPTH.
- full  out  1  cnt == DEPTH.
- ovf  out  1  sticky overflow flag.
- ovf_clr  in  1  clears ovf and drop_cnt.
- drop_cnt  out  8  words lost to overflow, saturates at 255.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wp = rp = 0, cnt = 0, full = 0, rd_vld = 0.
  - rd_adr = 0, rd_dat = 0, ovf = 0, drop_cnt = 0.
  - All 256 label-table bits = 1 (accept all).
  - Storage array is not reset.
  - Reset mid-operation discards all stored words; the first ce_wr after release is handled normally.
- Label table:
  - A rising edge with lbl_we=1 writes lbl_en into bit lbl_adr.
  - The new value is effective from the next edge.
  - If lbl_we and ce_wr coincide for the same label, filtering uses the old value.
- Capture, evaluated at each rising edge with ce_wr=1:
  - Table bit for sr_adr = 0: word ignored; no flag or counter change.
  - Table bit = 1 and slot available: mem[wp] <= {sr_adr, sr_dat}; wp <= wp+1 (mod DEPTH).
  - Slot available means full=0, or full=1 with a valid pop in the same cycle.
  - Table bit = 1 and full=1 with no pop: word dropped; ovf <= 1; drop_cnt <= min(drop_cnt+1, 255).
- Read (show-ahead):
  - rd_vld = (cnt != 0).
  - rd_adr/rd_dat = mem[rp] when rd_vld=1, else forced to 0.
  - A pop occurs at an edge with rd=1 and rd_vld=1: rp <= rp+1 (mod DEPTH).
  - rd while empty is ignored; no underflow state.
- Count and flags:
  - Push only: cnt+1. Pop only: cnt-1. Push and pop together: cnt unchanged.
  - Pointers wrap modulo DEPTH; cnt is the authoritative full/empty source.
  - full = (cnt == DEPTH), registered consistently with cnt.
- Latency:
  - A word strobed at edge N is visible on rd_vld/rd_adr/rd_dat after edge N (same cycle as the cnt update).
  - When the FIFO was empty, rd_vld goes 1 in cycle N+1.
- ovf_clr:
  - At an edge with ovf_clr=1: ovf <= 0, drop_cnt <= 0.
  - If a drop occurs in the same cycle, the drop wins: ovf <= 1, drop_cnt <= 1.
- Ordering: strictly FIFO; labels are not reordered or merged. Duplicate labels are stored as separate words.

Test Plan:
- Reset release, then ce_wr with sr_adr=8'h2A, sr_dat=23'h12345 -> next cycle rd_vld=1, rd_adr=8'h2A, rd_dat=23'h12345, cnt=1; pulse rd -> rd_vld=0, rd_adr=0, cnt=0.
- Write lbl_adr=8'h2A, lbl_en=0; send labels 8'h2A then 8'h2B -> only 8'h2B stored, cnt=1, ovf=0. Same-cycle lbl_we(8'h2B,0) plus ce_wr(8'h2B) -> 8'h2B still stored.
- Push 16 words (data 0..15) -> full=1, cnt=16. Push 3 more -> ovf=1, drop_cnt=3, contents unchanged. Pop all -> data 0..15 in order.
- While full, assert rd and ce_wr (data 23'h7FFFFF) in the same cycle -> cnt stays 16, ovf unchanged; tail of the FIFO reads 23'h7FFFFF.
- Overflow 300 words into a full FIFO -> drop_cnt=255. ovf_clr together with one more drop -> ovf=1, drop_cnt=1.
- Fill 10 words, drop rst_n asynchronously mid-cycle -> cnt=0, rd_vld=0, ovf=0, label table all-accept. Pointer wrap check: push/pop 40 words interleaved -> data order preserved.
